jk_ff_bank: RTL
===============

Name: jk_ff_bank

Overview:
- Parametrised multi-bit successor to the single JK flip-flop used in the lab sequence.
- WIDTH independent flip-flop channels share one clock. A run-time mode selects JK, D, T or serial-shift behaviour.
- Adds clock enable, synchronous parallel load, a per-bit change mask and a saturating change-event counter.
- Sits as a generic register primitive under the counter and shift-register labs.

Parameters:
- WIDTH, 4, number of flip-flop channels (>=1)
- CNT_W, 8, width of the change-event counter (>=1)
- RST_VAL, {WIDTH{1'b0}}, value Q takes on reset

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous reset, active-high
- CE  in  1  clock enable for mode operation
- MODE  in  2  00=JK, 01=D, 10=T, 11=SHIFT
- J  in  WIDTH  J inputs; D input in D mode; T input in T mode
- K  in  WIDTH  K inputs; used only in JK mode
- SI  in  1  serial input for SHIFT mode
- LOAD  in  1  synchronous parallel load
- D_IN  in  WIDTH  parallel load data
- CNT_CLR  in  1  synchronous clear of CNT
- Q  out  WIDTH  registered state
- Q_n  out  WIDTH  ~Q, combinational
- SO  out  1  Q[WIDTH-1], combinational
- CHG  out  WIDTH  registered mask of bits that changed at the last edge
- CNT  out  CNT_W  saturating count of edges at which Q changed

Behaviour:
- All state updates on the rising CLK edge. Clock and reset are as decided: one clock, synchronous active-high RST.
- Priority per edge is RST > LOAD > (CE and MODE) > hold.
- RST=1 at an edge:
  - Q=RST_VAL, CHG=0, CNT=0.
  - LOAD, CE and CNT_CLR are ignored.
  - Q_n=~RST_VAL and SO=RST_VAL[WIDTH-1] follow Q.
- LOAD=1 (RST=0): Q<=D_IN regardless of CE and MODE.
- CE=0 and LOAD=0: Q holds.
- CE=1 and LOAD=0, per bit i:
  - JK mode: J=0,K=0 hold; J=0,K=1 clear; J=1,K=0 set; J=1,K=1 toggle.
  - D mode: Q[i]<=J[i]; K is ignored.
  - T mode: Q[i]<=Q[i]^J[i].
  - SHIFT mode: Q<={Q[WIDTH-2:0],SI}. When WIDTH=1, Q<=SI.
- CHG is updated every non-reset edge with CHG<=Q_next^Q. It is therefore aligned with the new Q and is 0 on hold edges.
- CNT is evaluated every non-reset edge:
  - CNT_CLR=1: CNT<=0. Clear wins over a simultaneous change.
  - Else, if Q_next!=Q and CNT is below its maximum: CNT<=CNT+1.
  - At 2^CNT_W-1 the counter holds (saturates). It never wraps.
- Latency: one edge from inputs to Q, CHG and CNT. Q_n and SO have zero added latency from Q.
- No X propagation from unused inputs: K is ignored outside JK mode, SI is ignored outside SHIFT mode.

Decomposition:
- Shared package holds:
  - the MODE encodings MODE_JK=2'b00, MODE_D=2'b01, MODE_T=2'b10, MODE_SHIFT=2'b11;
  - the JK input-pair encodings used by benches.
- One natural sub-module, jk_ff_next: combinational next-state for a single bit.
  - Inputs: q, j, k, mode, shift_in. Output: q_next.
  - Instantiated WIDTH times via generate. Each bit's shift_in is Q[i-1], or SI for bit 0.
- The top level holds the Q/CHG/CNT registers and the priority logic.

Test Plan:
- Reset, WIDTH=4: hold RST=1 for 2 edges with LOAD=1, D_IN=4'b1111 -> Q=0000, Q_n=1111, CHG=0000, CNT=0.
- JK truth table: from Q=0000, MODE=JK, CE=1, J=0011, K=0101.
  - Edge 1 -> Q=0011, CHG=0011, CNT=1.
  - Edge 2 -> Q=0010, CHG=0001, CNT=2.
- Enable gating: CE=0, MODE=JK, J=K=1111 for 3 edges -> Q unchanged, CHG=0000, CNT unchanged.
  - Then LOAD=1, D_IN=1010 with CE=0 -> Q=1010 on the next edge.
- Shift: from Q=1010, MODE=SHIFT, CE=1, SI=1 for 4 edges -> Q=0101, 1011, 0111, 1111, with SO=0, 1, 0, 1 after each edge.
- Saturation, CNT_W=2 instance: MODE=T, J=0001 for 5 edges -> CNT=1, 2, 3, 3, 3.
  - Next edge with CNT_CLR=1 and a toggle still active -> CNT=0, Q toggles, CHG=0001.
- Reset mid-operation: during a SHIFT sequence assert RST with LOAD=1 and CNT_CLR=0 -> Q=RST_VAL, CHG=0, CNT=0 on that edge.
  - Operation resumes correctly on the following edge.

Source files
------------

// File: rtl/jk_ff_bank_pkg.sv
// Shared definitions for the JK/D/T/shift register bank: mode encodings and
// JK input-pair encodings.
package jk_ff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_JK    = 2'b00,
        MODE_D     = 2'b01,
        MODE_T     = 2'b10,
        MODE_SHIFT = 2'b11
    } mode_e;

    // {J,K} pair encodings, used by benches to build JK stimulus
    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_CLEAR  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_ff_next.sv
// Combinational next-state of one flip-flop channel for the selected mode.
module jk_ff_next
    import jk_ff_bank_pkg::*;
(
    input  logic  q,
    input  logic  j,
    input  logic  k,
    input  mode_e mode,
    input  logic  shift_in,
    output logic  q_next
);

    always_comb begin
        q_next = q;
        unique case (mode)
            MODE_JK: begin
                unique case ({j, k})
                    JK_HOLD:   q_next = q;
                    JK_CLEAR:  q_next = 1'b0;
                    JK_SET:    q_next = 1'b1;
                    JK_TOGGLE: q_next = ~q;
                    default:   q_next = q;
                endcase
            end
            MODE_D:     q_next = j;
            MODE_T:     q_next = q ^ j;
            MODE_SHIFT: q_next = shift_in;
            default:    q_next = q;
        endcase
    end

endmodule

// File: rtl/jk_ff_bank.sv
// WIDTH-channel flip-flop bank with run-time JK/D/T/shift mode, parallel load,
// per-bit change mask and a saturating change-event counter.
module jk_ff_bank
    import jk_ff_bank_pkg::*;
#(
    parameter int               WIDTH   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CE,
    input  logic [1:0]       MODE,
    input  logic [WIDTH-1:0] J,
    input  logic [WIDTH-1:0] K,
    input  logic             SI,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D_IN,
    input  logic             CNT_CLR,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_n,
    output logic             SO,
    output logic [WIDTH-1:0] CHG,
    output logic [CNT_W-1:0] CNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] shift_in;
    logic [WIDTH-1:0] q_mode;
    logic [WIDTH-1:0] q_next;
    mode_e            mode;

    assign mode = mode_e'(MODE);

    // Bit 0 takes the serial input; higher bits take their lower neighbour.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i == 0) begin : g_head
            assign shift_in[i] = SI;
        end else begin : g_body
            assign shift_in[i] = Q[i-1];
        end

        jk_ff_next u_next (
            .q        (Q[i]),
            .j        (J[i]),
            .k        (K[i]),
            .mode     (mode),
            .shift_in (shift_in[i]),
            .q_next   (q_mode[i])
        );
    end

    always_comb begin
        q_next = Q;
        if (LOAD)
            q_next = D_IN;
        else if (CE)
            q_next = q_mode;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q   <= RST_VAL;
            CHG <= '0;
            CNT <= '0;
        end else begin
            Q   <= q_next;
            CHG <= q_next ^ Q;
            if (CNT_CLR)
                CNT <= '0;
            else if ((q_next != Q) && (CNT != CNT_MAX))
                CNT <= CNT + 1'b1;
        end
    end

    assign Q_n = ~Q;
    assign SO  = Q[WIDTH-1];

endmodule
